// File: rtl/exe_wb_arbiter.sv
// Round-robin writeback arbiter: picks one execution unit per cycle and holds
// the winner in a one-entry output register that feeds the ROB completion port.
module exe_wb_arbiter #(
  parameter int DATA      = 32,
  parameter int ROB_DEPTH = 16,
  parameter int NREQ      = 4,
  localparam int ROBW     = $clog2(ROB_DEPTH),
  localparam int SRCW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*ROBW-1:0] req_rob_id,
  input  logic [NREQ*DATA-1:0] req_data,
  input  logic [NREQ-1:0]      req_exp,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ROBW-1:0]      wb_rob_id,
  output logic [DATA-1:0]      wb_data,
  output logic                 wb_exp,
  output logic [SRCW-1:0]      wb_src
);

  logic            r_valid;
  logic [ROBW-1:0] r_rob_id;
  logic [DATA-1:0] r_data;
  logic            r_exp;
  logic [SRCW-1:0] r_src;
  logic [SRCW-1:0] r_ptr;

  logic            w_allow;
  logic            w_any;
  logic [SRCW-1:0] w_win;
  logic [SRCW:0]   w_idx;
  logic            w_xfer;
  logic [SRCW-1:0] w_ptr_nxt;

  // Scan from the farthest slot back toward ptr so the first match in
  // round-robin order is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (SRCW+1)'(k);
      if (w_idx >= (SRCW+1)'(NREQ)) w_idx = w_idx - (SRCW+1)'(NREQ);
      if (req_valid[w_idx[SRCW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[SRCW-1:0];
      end
    end
  end

  assign w_allow = !reset && !flush && (!r_valid || wb_ready);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_allow && w_any && (w_win == SRCW'(i));
    end
  end

  assign w_xfer    = w_allow && w_any;
  assign w_ptr_nxt = (w_win == SRCW'(NREQ - 1)) ? '0 : w_win + SRCW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_rob_id <= '0;
      r_data   <= '0;
      r_exp    <= 1'b0;
      r_src    <= '0;
      r_ptr    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid  <= 1'b1;
      r_rob_id <= req_rob_id[w_win*ROBW +: ROBW];
      r_data   <= req_data[w_win*DATA +: DATA];
      r_exp    <= req_exp[w_win];
      r_src    <= w_win;
      r_ptr    <= w_ptr_nxt;
    end else if (wb_ready) begin
      // Drained with nothing to replace it; payload is left as don't-care.
      r_valid <= 1'b0;
    end
  end

  assign wb_valid  = r_valid;
  assign wb_rob_id = r_rob_id;
  assign wb_data   = r_data;
  assign wb_exp    = r_exp;
  assign wb_src    = r_src;

endmodule
